sha2_512_core: RTL

- Iterative SHA-2 64-bit-family compression engine with runtime mode select: SHA-512/224, SHA-512/256, SHA-384, SHA-512.
- Takes one pre-padded 1024-bit block per handshake and chains blocks of a multi-block message.
- Emits a left-aligned, mode-truncated digest. Padding and message framing are handled upstream.
- Performs UNROLL rounds per clock.

---
 rtl/sha2_512_core.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sha2_512_core.sv
// Iterative SHA-2 64-bit compression core (512/224, 512/256, 384, 512), UNROLL rounds per clock.
// Optional macro SHA2_ABORT_EN adds an abort input that drops the block in flight.
module sha2_512_core #(
    parameter int UNROLL = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1023:0] Data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          first,
    input  logic [1:0]    mode,
    output logic [511:0]  Hash,
    output logic          out_valid
`ifdef SHA2_ABORT_EN
    ,
    input  logic          abort
`endif
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 5 ||
              UNROLL == 8 || UNROLL == 10 || UNROLL == 16)) begin : g_bad_unroll
            $error("sha2_512_core: UNROLL must divide 80 and be one of 1,2,4,5,8,10,16");
        end
    endgenerate

    localparam logic [63:0] K [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    // Word 7 of every 8-word vector is H0 / a, so the chain maps straight onto Hash[511:0].
    function automatic logic [511:0] iv(input logic [1:0] m);
        case (m)
            2'd0:    iv = {64'h8c3d37c819544da2, 64'h73e1996689dcd4d6, 64'h1dfab7ae32ff9c82, 64'h679dd514582f9fcf,
                           64'h0f6d2b697bd44da8, 64'h77e36f7304c48942, 64'h3f9d85a86a1d36c8, 64'h1112e6ad91d692a1};
            2'd1:    iv = {64'h22312194fc2bf72c, 64'h9f555fa3c84c64c2, 64'h2393b86b6f53b151, 64'h963877195940eabd,
                           64'h96283ee2a88effe3, 64'hbe5e1e2553863992, 64'h2b0199fc2c85b8aa, 64'h0eb72ddc81c52ca2};
            2'd2:    iv = {64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
                           64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
            default: iv = {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                           64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
        endcase
    endfunction

    function automatic logic [511:0] trunc_mask(input logic [1:0] m);
        case (m)
            2'd0:    trunc_mask = {{224{1'b1}}, {288{1'b0}}};
            2'd1:    trunc_mask = {{256{1'b1}}, {256{1'b0}}};
            2'd2:    trunc_mask = {{384{1'b1}}, {128{1'b0}}};
            default: trunc_mask = {512{1'b1}};
        endcase
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        rotr = (x >> n) | (x << (64 - n));
    endfunction

    logic [1:0]         state;
    logic [6:0]         t;
    logic [1:0]         mode_q;
    logic [7:0][63:0]   wk, hc, wk_n, hsum;
    logic [15:0][63:0]  win, win_n;
    logic               abort_i;

`ifdef SHA2_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign in_ready = (state == S_IDLE);

    // win[15] is W[t]; each round appends W[t+16] at the bottom of the window.
    always_comb begin : rounds
        logic [63:0] t1, t2, nw;
        t1    = '0;
        t2    = '0;
        nw    = '0;
        wk_n  = wk;
        win_n = win;
        for (int u = 0; u < UNROLL; u++) begin
            t1 = wk_n[0] + (rotr(wk_n[3], 14) ^ rotr(wk_n[3], 18) ^ rotr(wk_n[3], 41))
               + ((wk_n[3] & wk_n[2]) ^ (~wk_n[3] & wk_n[1])) + K[t + 7'(u)] + win_n[15];
            t2 = (rotr(wk_n[7], 28) ^ rotr(wk_n[7], 34) ^ rotr(wk_n[7], 39))
               + ((wk_n[7] & wk_n[6]) ^ (wk_n[7] & wk_n[5]) ^ (wk_n[6] & wk_n[5]));
            nw = (rotr(win_n[1], 19) ^ rotr(win_n[1], 61) ^ (win_n[1] >> 6)) + win_n[6]
               + (rotr(win_n[14], 1) ^ rotr(win_n[14], 8) ^ (win_n[14] >> 7)) + win_n[15];
            wk_n  = {t1 + t2, wk_n[7], wk_n[6], wk_n[5], wk_n[4] + t1, wk_n[3], wk_n[2], wk_n[1]};
            win_n = {win_n[14:0], nw};
        end
    end

    always_comb begin
        hsum = '0;
        for (int i = 0; i < 8; i++) hsum[i] = hc[i] + wk[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            t         <= '0;
            mode_q    <= '0;
            wk        <= '0;
            hc        <= '0;
            win       <= '0;
            Hash      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: if (in_valid) begin
                    win   <= Data;
                    t     <= '0;
                    state <= S_ROUND;
                    if (first) begin
                        mode_q <= mode;
                        hc     <= iv(mode);
                        wk     <= iv(mode);
                    end else begin
                        wk <= hc;
                    end
                end
                S_ROUND: if (abort_i) begin
                    state <= S_IDLE;
                end else begin
                    wk  <= wk_n;
                    win <= win_n;
                    t   <= t + 7'(UNROLL);
                    if (t == 7'(80 - UNROLL)) state <= S_FINAL;
                end
                S_FINAL: begin
                    state <= S_IDLE;
                    if (!abort_i) begin
                        hc        <= hsum;
                        Hash      <= hsum & trunc_mask(mode_q);
                        out_valid <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
